// File: rtl/fir_mdc_tcdm_responder_pkg.sv
// Shared TCDM bus widths, request/response bundles and small helpers for the
// fir_mdc TCDM responder.
package fir_mdc_tcdm_responder_pkg;

  localparam int TCDM_DW  = 32;
  localparam int TCDM_AW  = 32;
  localparam int TCDM_BEW = 4;

  typedef struct packed {
    logic [TCDM_AW-1:0]  add;
    logic                wen;
    logic [TCDM_BEW-1:0] be;
    logic [TCDM_DW-1:0]  data;
  } tcdm_req_t;

  typedef struct packed {
    logic [TCDM_DW-1:0] r_data;
    logic               r_valid;
  } tcdm_resp_t;

  // Index width that never collapses to zero bits, so vectors stay declarable.
  function automatic int clog2_min1(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/fir_mdc_tcdm_responder_rr_arbiter.sv
// NP-way round-robin arbiter for one memory bank. The search starts at the
// pointer and wraps upward; the pointer moves past the winner only when a
// grant is actually issued.
module fir_mdc_rr_arbiter
  import fir_mdc_tcdm_responder_pkg::*;
#(
  parameter int NP = 2
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          clear_i,
  input  logic          en_i,
  input  logic [NP-1:0] req_i,
  output logic [NP-1:0] gnt_o
);

  localparam int PW = clog2_min1(NP);

  logic [PW-1:0] ptr_q, ptr_d;
  logic [PW-1:0] idx;
  logic          found;

  // Pick the first requester at or after the pointer; a disabled arbiter grants nothing.
  always_comb begin
    gnt_o = '0;
    ptr_d = ptr_q;
    idx   = '0;
    found = 1'b0;
    if (en_i) begin
      for (int i = 0; i < NP; i++) begin
        idx = PW'((int'(ptr_q) + i) % NP);
        if (!found && req_i[idx]) begin
          gnt_o[idx] = 1'b1;
          ptr_d      = PW'((int'(idx) + 1) % NP);
          found      = 1'b1;
        end
      end
    end
  end

  // Pointer register, returned to port 0 on reset or clear.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i)        ptr_q <= '0;
    else if (clear_i) ptr_q <= '0;
    else              ptr_q <= ptr_d;
  end

endmodule

// File: rtl/fir_mdc_tcdm_responder.sv
// Multi-bank, word-interleaved TCDM scratchpad. Each bank arbitrates its
// requesters round-robin; reads answer one cycle after the grant. An optional
// LFSR withholds all grants on pseudo-random cycles to exercise back-pressure.
module fir_mdc_tcdm_responder
  import fir_mdc_tcdm_responder_pkg::*;
#(
  parameter int          NP         = 2,
  parameter int          NB         = 4,
  parameter int          BANK_WORDS = 256,
  parameter bit          STALL_EN   = 1'b0,
  parameter logic [15:0] LFSR_SEED  = 16'hACE1
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   clear_i,
  input  logic [NP-1:0]          tcdm_req_i,
  output logic [NP-1:0]          tcdm_gnt_o,
  input  logic [NP*TCDM_AW-1:0]  tcdm_add_i,
  input  logic [NP-1:0]          tcdm_wen_i,
  input  logic [NP*TCDM_BEW-1:0] tcdm_be_i,
  input  logic [NP*TCDM_DW-1:0]  tcdm_data_i,
  output logic [NP*TCDM_DW-1:0]  tcdm_r_data_o,
  output logic [NP-1:0]          tcdm_r_valid_o
);

  // Bank bits are zero for a single bank; the flat memory index is {row, bank}.
  localparam int BANK_BITS = $clog2(NB);
  localparam int BIW       = clog2_min1(NB);
  localparam int ROW_BITS  = $clog2(BANK_WORDS);
  localparam int IDX_BITS  = (BANK_BITS + ROW_BITS > 0) ? BANK_BITS + ROW_BITS : 1;
  localparam int MEM_WORDS = NB * BANK_WORDS;

  tcdm_req_t           req_s    [NP];
  logic [BIW-1:0]      bank_sel [NP];
  logic [IDX_BITS-1:0] word_idx [NP];
  logic [NP-1:0]       bank_req [NB];
  logic [NP-1:0]       bank_gnt [NB];
  logic [NP-1:0]       gnt;
  logic                stall;
  logic                grant_en;
  tcdm_resp_t          resp_q   [NP];
  logic [TCDM_DW-1:0]  mem_q    [MEM_WORDS];

  // Byte offset and address bits above the bank/row field are deliberately ignored.
  logic unused_addr_bits;
  assign unused_addr_bits = ^tcdm_add_i;

  // Unflatten the port bundles and decode bank and flat word index.
  always_comb begin
    for (int p = 0; p < NP; p++) begin
      req_s[p].add  = tcdm_add_i[p*TCDM_AW +: TCDM_AW];
      req_s[p].wen  = tcdm_wen_i[p];
      req_s[p].be   = tcdm_be_i[p*TCDM_BEW +: TCDM_BEW];
      req_s[p].data = tcdm_data_i[p*TCDM_DW +: TCDM_DW];
      bank_sel[p]   = (NB > 1) ? req_s[p].add[2 +: BIW] : '0;
      word_idx[p]   = req_s[p].add[2 +: IDX_BITS];
    end
  end

  // Route each port's request to the arbiter of the bank it addresses.
  always_comb begin
    for (int b = 0; b < NB; b++) begin
      bank_req[b] = '0;
      for (int p = 0; p < NP; p++) begin
        bank_req[b][p] = tcdm_req_i[p] && (bank_sel[p] == BIW'(b));
      end
    end
  end

  if (STALL_EN) begin : g_lfsr
    logic [15:0] lfsr_q, lfsr_d;
    // Fibonacci LFSR, taps 16/14/13/11, shifting toward bit 0.
    assign lfsr_d = {lfsr_q[0] ^ lfsr_q[2] ^ lfsr_q[3] ^ lfsr_q[5], lfsr_q[15:1]};
    // LFSR state register, reseeded on reset or clear.
    always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i)        lfsr_q <= LFSR_SEED;
      else if (clear_i) lfsr_q <= LFSR_SEED;
      else              lfsr_q <= lfsr_d;
    end
    assign stall = lfsr_q[0];
  end else begin : g_no_lfsr
    logic unused_seed;
    assign unused_seed = ^LFSR_SEED;
    assign stall       = 1'b0;
  end

  // Reset and clear also suppress grants so no request completes without its response.
  assign grant_en = !stall && !rst_i && !clear_i;

  for (genvar gb = 0; gb < NB; gb++) begin : g_bank
    fir_mdc_rr_arbiter #(.NP(NP)) u_arb (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .clear_i (clear_i),
      .en_i    (grant_en),
      .req_i   (bank_req[gb]),
      .gnt_o   (bank_gnt[gb])
    );
  end

  // A port addresses a single bank, so OR-ing the per-bank grants is exact.
  always_comb begin
    gnt = '0;
    for (int b = 0; b < NB; b++) gnt |= bank_gnt[b];
  end

  assign tcdm_gnt_o = gnt;

  // Granted writes update the enabled bytes; the array itself is never reset.
  always_ff @(posedge clk_i) begin
    for (int p = 0; p < NP; p++) begin
      if (gnt[p] && !req_s[p].wen) begin
        for (int i = 0; i < TCDM_BEW; i++) begin
          if (req_s[p].be[i]) mem_q[word_idx[p]][i*8 +: 8] <= req_s[p].data[i*8 +: 8];
        end
      end
    end
  end

  // Read responses one cycle after the grant; data holds between responses.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int p = 0; p < NP; p++) resp_q[p] <= '0;
    end else if (clear_i) begin
      for (int p = 0; p < NP; p++) resp_q[p] <= '0;
    end else begin
      for (int p = 0; p < NP; p++) begin
        resp_q[p].r_valid <= gnt[p] && req_s[p].wen;
        if (gnt[p] && req_s[p].wen) resp_q[p].r_data <= mem_q[word_idx[p]];
      end
    end
  end

  // Flatten the response registers onto the output ports.
  always_comb begin
    tcdm_r_data_o  = '0;
    tcdm_r_valid_o = '0;
    for (int p = 0; p < NP; p++) begin
      tcdm_r_data_o[p*TCDM_DW +: TCDM_DW] = resp_q[p].r_data;
      tcdm_r_valid_o[p]                   = resp_q[p].r_valid;
    end
  end

endmodule
